// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor: opcodes, instruction width and
// the sequencer state encoding.
package proc_pkg;

   localparam int INST_W = 8;

   localparam logic [3:0] OP_LD  = 4'b0000;
   localparam logic [3:0] OP_ST  = 4'b0001;
   localparam logic [3:0] OP_MI  = 4'b0010;
   localparam logic [3:0] OP_MR  = 4'b0011;
   localparam logic [3:0] OP_SUM = 4'b0100;
   localparam logic [3:0] OP_SB  = 4'b0101;
   localparam logic [3:0] OP_ANR = 4'b0110;
   localparam logic [3:0] OP_CM  = 4'b0111;
   localparam logic [3:0] OP_ORR = 4'b1000;
   localparam logic [3:0] OP_ORI = 4'b1001;
   localparam logic [3:0] OP_XRR = 4'b1010;
   localparam logic [3:0] OP_XRI = 4'b1011;
   localparam logic [3:0] OP_SMI = 4'b1100;
   localparam logic [3:0] OP_SBI = 4'b1101;
   localparam logic [3:0] OP_ANI = 4'b1110;
   localparam logic [3:0] OP_CMI = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } seq_state_t;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait counter: synchronous clear, count enable, expired when count == limit.
// Latency: expired is combinational from the registered count; no backpressure.
module seq_wait_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   assign expired = (cnt == limit);

   // Counting stops at the limit so a stalled owner never wraps back to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer owning pc, ir and the retired count.
// Latency 4 cycles per instruction plus memory wait cycles; optional INSTR_SEQUENCER_STEP_EN single-steps on step edges.
module instr_sequencer
   import proc_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int MEM_TIMEOUT = 15,
   parameter int RET_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
`ifdef INSTR_SEQUENCER_STEP_EN
   input  logic              step,
`endif
   input  logic              halt_req,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              imem_valid,
   output logic              imem_req,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] ir,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ready,
   output logic              alu_en,
   output logic              rf_we,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [RET_W-1:0]  retired
);

   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   seq_state_t state, state_nxt;
   logic       start, cont;
   logic       wait_clr, wait_en, wait_exp;
   logic       ir_ld, wb_do, tmo;

`ifdef INSTR_SEQUENCER_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         step_q <= 1'b0;
      else
         step_q <= step;
   end

   assign start = step & ~step_q;
   assign cont  = 1'b0;
`else
   assign start = run;
   assign cont  = run;
`endif

   seq_wait_timer #(.CNT_W(8)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clr     (wait_clr),
      .en      (wait_en),
      .limit   (TMO_LIMIT),
      .expired (wait_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Strobes decode from the state register only, so reset removes them at once.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      alu_en    = 1'b0;
      rf_we     = 1'b0;
      wait_clr  = 1'b1;
      wait_en   = 1'b0;
      ir_ld     = 1'b0;
      wb_do     = 1'b0;
      tmo       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            wait_clr = 1'b0;
            if (imem_valid) begin
               ir_ld     = 1'b1;
               state_nxt = S_DECODE;
            end else if (wait_exp) begin
               tmo       = 1'b1;
               state_nxt = S_HALT;
            end else begin
               wait_en = 1'b1;
            end
         end
         S_DECODE: begin
            state_nxt = is_mem_op(ir[7:4]) ? S_MEM : S_EXEC;
         end
         S_EXEC: begin
            alu_en    = 1'b1;
            state_nxt = S_WB;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (ir[7:4] == OP_ST);
            wait_clr = 1'b0;
            if (dmem_ready) begin
               state_nxt = S_WB;
            end else if (wait_exp) begin
               tmo       = 1'b1;
               state_nxt = S_HALT;
            end else begin
               wait_en = 1'b1;
            end
         end
         S_WB: begin
            rf_we = (ir[7:4] != OP_ST);
            wb_do = 1'b1;
            if (halt_req)
               state_nxt = S_HALT;
            else if (!cont)
               state_nxt = S_IDLE;
            else
               state_nxt = S_FETCH;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= '0;
         ir      <= '0;
         retired <= '0;
         err     <= 1'b0;
      end else begin
         if (ir_ld)
            ir <= imem_rdata;
         if (wb_do) begin
            pc <= pc + PC_W'(1);
            if (retired != {RET_W{1'b1}})
               retired <= retired + RET_W'(1);
         end
         if (tmo)
            err <= 1'b1;
      end
   end

   assign busy   = (state != S_IDLE) && (state != S_HALT);
   assign halted = (state == S_HALT);

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit processor.
- Owns the PC and instruction register, and handshakes with instruction and data memory.
- Issues one-cycle strobes that step the control unit, ALU and register file through each 8-bit instruction (opcode in inst[7:4]).
- Sits between the memories and the decoder; the decoder stays purely a decoder.

Parameters:
- PC_W, 8: program counter width; PC wraps modulo 2^PC_W.
- MEM_TIMEOUT, 15: maximum wait cycles for imem_valid or dmem_ready before error; legal range 1..255.
- RET_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; high allows fetching.
- halt_req  in  1  request to stop after the current instruction.
- imem_rdata  in  8  instruction word.
- imem_valid  in  1  instruction word valid.
- imem_req  out  1  instruction fetch request.
- pc  out  PC_W  current fetch address.
- ir  out  8  latched instruction, to the control unit.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  write qualifier for dmem_req (ST).
- dmem_ready  in  1  data access complete.
- alu_en  out  1  one-cycle ALU evaluate strobe.
- rf_we  out  1  one-cycle register-file write strobe.
- busy  out  1  high in any state other than IDLE or HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky memory-timeout flag.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - pc=0, ir=8'h00, retired=0, err=0.
  - All strobes and requests are 0.
- State machine states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH:
  - imem_req=1 and is held until imem_valid=1.
  - On imem_valid=1, ir<=imem_rdata and go to DECODE; imem_req drops the following cycle.
- DECODE (1 cycle): opcode 4'b0000 (LD) or 4'b0001 (ST) goes to MEM; any other opcode goes to EXEC.
- EXEC: alu_en=1 for exactly one cycle, then WB.
- MEM:
  - dmem_req=1, with dmem_we=1 only for ST.
  - Both are held until dmem_ready=1, then go to WB.
- WB (1 cycle):
  - rf_we=1 for every opcode except ST.
  - pc<=pc+1, wrapping from all-ones to 0.
  - retired<=retired+1, saturating at all-ones.
  - Next state: HALT if halt_req=1; else IDLE if run=0; else FETCH.
- HALT:
  - halted=1; all strobes 0.
  - Exit only via reset; run and halt_req are ignored.
- Latency: 4 cycles per instruction (FETCH, DECODE, EXEC/MEM, WB) when valid/ready arrive in the cycle of the request; each wait cycle adds 1.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle valid/ready is low.
  - When it reaches MEM_TIMEOUT with valid/ready still low: err<=1, requests drop, go to HALT.
  - No WB, no pc change, no retired increment.
  - valid/ready arriving in the same cycle the count is reached wins (no error).
- Boundary behaviour:
  - run falling mid-instruction: the instruction completes through WB, then IDLE.
  - halt_req: sampled only in WB; a pulse outside WB is ignored.
  - halt_req=1 and run=0 together in WB: HALT takes priority.
  - imem_valid/dmem_ready outside FETCH/MEM: ignored.
  - Reset mid-MEM: dmem_req drops immediately (asynchronously).
- alu_en, rf_we, dmem_req and imem_req are never high in the same cycle.

Optional Feature:
- Macro: INSTR_SEQUENCER_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In IDLE, FETCH starts only on a rising edge of step (registered edge detect); run is ignored for starting.
  - WB always returns to IDLE (or HALT if halt_req=1), so exactly one instruction runs per step pulse.
- Undefined: step port absent; run governs as above.

Decomposition:
- Package proc_pkg:
  - Opcode localparams OP_LD=4'b0000, OP_ST=4'b0001, OP_MI, OP_MR, OP_SUM, OP_SB, OP_ANR, OP_CM, OP_ORR, OP_ORI, OP_XRR, OP_XRI, OP_SMI, OP_SBI, OP_ANI, OP_CMI.
  - typedef seq_state_t for the seven states.
  - Constant INST_W=8.
- Sub-module seq_wait_timer:
  - Counter with clear, enable and limit inputs, and an expired output.
  - Instantiated once and shared between FETCH and MEM.

Test Plan:
1. run=1; imem returns 8'h4E (SUM) with valid in the request cycle -> alu_en at cycle 3, rf_we at cycle 4, pc 0->1, retired=1, next imem_req at cycle 5.
2. imem returns 8'h05 (LD); dmem_ready delayed 3 cycles -> dmem_req/dmem_we=1/0 held 4 cycles, rf_we pulse, instruction takes 7 cycles.
3. imem returns 8'h13 (ST) -> dmem_we=1 during MEM; rf_we stays 0 in WB; retired increments.
4. MEM_TIMEOUT=15 with imem_valid held low -> err=1 and halted=1 after 15 wait cycles; pc unchanged; no rf_we.
5. pc=8'hFF executing XRR (8'hA6) -> pc wraps to 8'h00; halt_req pulsed in that WB -> HALT, busy=0.
6. reset asserted mid-MEM -> dmem_req=0 immediately; after release, state IDLE with pc=0 and retired=0.
